// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command receiver:
//   - CMD_HEADER        : upper five bits every command header byte must carry
//   - DEFAULT_*         : default baud divider and inter-byte timeout
//   - rx_state_t        : bit-engine states of uart_rx_core
//   - asm_state_t       : frame-assembler states of uart_cmd_rx
//   - is_header()       : header-byte recogniser
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

    localparam logic [4:0] CMD_HEADER = 5'b10100;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_TIMEOUT_BITS = 32;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        ASM_HDR,
        ASM_GET_A,
        ASM_GET_B
    } asm_state_t;

    function automatic logic is_header(input logic [7:0] hdr_byte);
        return (hdr_byte[7:3] == CMD_HEADER);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART byte receiver: 2-flop input synchroniser, baud counter and bit
// engine.
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   rx          in   raw serial line, idles high
//   byte_valid  out  one-cycle pulse, registered one clock after a good stop
//   data        out  received byte, valid while byte_valid is high
//   stop_error  out  one-cycle pulse when the stop bit samples low
//   line_idle   out  bit engine is waiting for a start bit
// ---------------------------------------------------------------------------
module uart_rx_core
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       stop_error,
    output logic       line_idle
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta;
    logic             rx_s;
    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_next;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic             byte_valid_next;
    logic             stop_error_next;

    // Synchroniser flops reset high so that reset release never looks like
    // a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RX_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            byte_valid <= 1'b0;
            stop_error <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_cnt_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            byte_valid <= byte_valid_next;
            stop_error <= stop_error_next;
        end
    end

    // The start bit is sampled half a bit in, so every later sample taken a
    // full bit period apart lands near the middle of its bit. The baud
    // counter is held at zero in IDLE and BREAK so each state starts from 0.
    always_comb begin
        state_next      = state;
        baud_cnt_next   = baud_cnt + CNT_W'(1);
        bit_cnt_next    = bit_cnt;
        shift_next      = shift_reg;
        byte_valid_next = 1'b0;
        stop_error_next = 1'b0;

        case (state)
            RX_IDLE: begin
                baud_cnt_next = '0;
                if (!rx_s) begin
                    state_next   = RX_START;
                    bit_cnt_next = '0;
                end
            end
            RX_START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_cnt_next = '0;
                    state_next    = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_cnt == FULL_LAST) begin
                    baud_cnt_next = '0;
                    shift_next    = {rx_s, shift_reg[7:1]};
                    bit_cnt_next  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (baud_cnt == FULL_LAST) begin
                    baud_cnt_next = '0;
                    if (rx_s) begin
                        byte_valid_next = 1'b1;
                        state_next      = RX_IDLE;
                    end else begin
                        stop_error_next = 1'b1;
                        state_next      = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // A line held low reports one error, not one per bit time
                baud_cnt_next = '0;
                if (rx_s) begin
                    state_next = RX_IDLE;
                end
            end
            default: begin
                baud_cnt_next = '0;
                state_next    = RX_IDLE;
            end
        endcase
    end

    assign data      = shift_reg;
    assign line_idle = (state == RX_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx
// Assembles three-byte UART command frames (header+opcode, a, b) into one
// operand/opcode set for the ALU datapath.
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   rx           in   raw serial line, idles high
//   a            out  operand A of the last accepted command
//   b            out  operand B of the last accepted command
//   opcode       out  opcode of the last accepted command
//   cmd_valid    out  one-cycle pulse when a/b/opcode update
//   frame_error  out  one-cycle pulse on any discarded byte or frame
//   busy         out  high while a frame is partially received
// ---------------------------------------------------------------------------
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [2:0] opcode,
    output logic       cmd_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

    logic             byte_valid;
    logic [7:0]       rx_data;
    logic             stop_error;
    logic             line_idle;

    asm_state_t       asm_state;
    asm_state_t       asm_state_next;
    logic [2:0]       pend_op;
    logic [7:0]       pend_a;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout_hit;
    logic             load_op;
    logic             load_a;
    logic             load_out;
    logic             cmd_valid_next;
    logic             frame_error_next;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .data       (rx_data),
        .stop_error (stop_error),
        .line_idle  (line_idle)
    );

    // A byte arriving in the same cycle always beats the timeout
    assign timeout_hit = (asm_state != ASM_HDR) && line_idle && !byte_valid &&
                         (to_cnt == TO_LAST);

    // Idle-time counter for a partial frame. Any start detection takes the
    // bit engine out of IDLE, which clears the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if ((asm_state == ASM_HDR) || byte_valid || !line_idle || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            asm_state   <= ASM_HDR;
            pend_op     <= '0;
            pend_a      <= '0;
            a           <= '0;
            b           <= '0;
            opcode      <= '0;
            cmd_valid   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            asm_state   <= asm_state_next;
            cmd_valid   <= cmd_valid_next;
            frame_error <= frame_error_next;
            if (load_op) begin
                pend_op <= rx_data[2:0];
            end
            if (load_a) begin
                pend_a <= rx_data;
            end
            // Outputs only ever change together, on a complete frame
            if (load_out) begin
                opcode <= pend_op;
                a      <= pend_a;
                b      <= rx_data;
            end
        end
    end

    // A stop-bit error discards the whole frame wherever it occurs; in HDR
    // there is no frame yet, but the dropped byte is still reported.
    always_comb begin
        asm_state_next   = asm_state;
        load_op          = 1'b0;
        load_a           = 1'b0;
        load_out         = 1'b0;
        cmd_valid_next   = 1'b0;
        frame_error_next = 1'b0;

        if (byte_valid) begin
            case (asm_state)
                ASM_HDR: begin
                    if (is_header(rx_data)) begin
                        load_op        = 1'b1;
                        asm_state_next = ASM_GET_A;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end
                ASM_GET_A: begin
                    load_a         = 1'b1;
                    asm_state_next = ASM_GET_B;
                end
                ASM_GET_B: begin
                    load_out       = 1'b1;
                    cmd_valid_next = 1'b1;
                    asm_state_next = ASM_HDR;
                end
                default: begin
                    asm_state_next = ASM_HDR;
                end
            endcase
        end else if (stop_error) begin
            frame_error_next = 1'b1;
            asm_state_next   = ASM_HDR;
        end else if (timeout_hit) begin
            frame_error_next = 1'b1;
            asm_state_next   = ASM_HDR;
        end
    end

    assign busy = (asm_state != ASM_HDR);

endmodule
